// File: rtl/trap_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_resolve_pkg
// Description : Shared constants for trap resolution: interrupt indices,
//               exception codes, privilege modes, interrupt priority order
//               and WFI state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_resolve_pkg;

    localparam int c_NUM_INT = 12;

    // Privilege mode encodings
    localparam logic [1:0] c_PRIV_U = 2'b00;
    localparam logic [1:0] c_PRIV_S = 2'b01;
    localparam logic [1:0] c_PRIV_M = 2'b11;

    // Interrupt bit indices
    localparam logic [3:0] c_INT_MEI  = 4'd11;
    localparam logic [3:0] c_INT_MSI  = 4'd3;
    localparam logic [3:0] c_INT_MTI  = 4'd7;
    localparam logic [3:0] c_INT_SEI  = 4'd9;
    localparam logic [3:0] c_INT_SSI  = 4'd1;
    localparam logic [3:0] c_INT_STI  = 4'd5;
    localparam logic [3:0] c_INT_VSEI = 4'd10;
    localparam logic [3:0] c_INT_VSSI = 4'd2;
    localparam logic [3:0] c_INT_VSTI = 4'd6;

    // Exception raised by a WFI timeout
    localparam logic [3:0] c_EXC_ILLEGAL_INSTR = 4'd2;

    // Interrupt priority, entry 0 is the highest
    localparam logic [3:0] c_INT_PRIO [c_NUM_INT] = '{
        c_INT_MEI, c_INT_MSI, c_INT_MTI, c_INT_SEI, c_INT_SSI, c_INT_STI,
        c_INT_VSEI, c_INT_VSSI, c_INT_VSTI, 4'd0, 4'd4, 4'd8
    };

    // Only the VS-level interrupts (2, 6, 10) may be delegated to VS
    localparam logic [c_NUM_INT-1:0] c_VS_INT_MASK = 12'h444;

    // WFI state machine encoding
    typedef logic [0:0] wfi_state_t;
    localparam wfi_state_t c_ST_RUN  = 1'b0;
    localparam wfi_state_t c_ST_WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/trap_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_resolve_if
// Description : Pipeline/CSR inputs and trap/return outputs of the trap
//               resolver. master = resolver, slave = pipeline/CSR side.
// Revision    : 1.0 - initial release
// ============================================================================
interface trap_resolve_if;
    logic        StallW;
    logic        InstrValidM;
    logic        ExceptionM;
    logic [3:0]  ExcCodeM;
    logic [11:0] MIP_MIE;
    logic [11:0] MIDELEG;
    logic [15:0] MEDELEG;
    logic [11:0] HIDELEG;
    logic [15:0] HEDELEG;
    logic [1:0]  PrivilegeModeW;
    logic        VirtModeW;
    logic        STATUS_MIE;
    logic        STATUS_SIE;
    logic        VSSTATUS_SIE;
    logic        STATUS_TW;
    logic        wfiM;
    logic        TrapM;
    logic        InterruptM;
    logic [3:0]  CauseM;
    logic        DelegateM;
    logic        TrapToM;
    logic        TrapToHS;
    logic        TrapToVS;
    logic        WFIStallM;

    modport master (
        input  StallW, InstrValidM, ExceptionM, ExcCodeM, MIP_MIE, MIDELEG,
               MEDELEG, HIDELEG, HEDELEG, PrivilegeModeW, VirtModeW,
               STATUS_MIE, STATUS_SIE, VSSTATUS_SIE, STATUS_TW, wfiM,
        output TrapM, InterruptM, CauseM, DelegateM, TrapToM, TrapToHS,
               TrapToVS, WFIStallM
    );

    modport slave (
        output StallW, InstrValidM, ExceptionM, ExcCodeM, MIP_MIE, MIDELEG,
               MEDELEG, HIDELEG, HEDELEG, PrivilegeModeW, VirtModeW,
               STATUS_MIE, STATUS_SIE, VSSTATUS_SIE, STATUS_TW, wfiM,
        input  TrapM, InterruptM, CauseM, DelegateM, TrapToM, TrapToHS,
               TrapToVS, WFIStallM
    );
endinterface
`default_nettype wire

// File: rtl/trap_resolve_int_priority.sv
`default_nettype none
// ============================================================================
// Module      : int_priority
// Description : Picks the highest-priority set bit of a 12-bit enabled
//               interrupt mask, following the fixed priority table.
// Revision    : 1.0 - initial release
// ============================================================================
module int_priority
    import trap_resolve_pkg::*;
(
    input  wire logic [c_NUM_INT-1:0] i_mask,
    output logic      [3:0]           o_idx,
    output logic                      o_valid
);

    // Walk from lowest to highest priority so the highest set bit wins last
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = c_NUM_INT - 1; k >= 0; k--) begin
            if (i_mask[c_INT_PRIO[k]]) begin
                o_idx   = c_INT_PRIO[k];
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_resolve.sv
`default_nettype none
// ============================================================================
// Module      : trap_resolve
// Description : Arbitrates interrupts against the M-stage exception, picks
//               the cause, resolves the M/HS/VS target and runs the WFI
//               wait/timeout state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_resolve
    import trap_resolve_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int S_SUPPORTED = 1,
    parameter int H_SUPPORTED = 1,
    parameter int WFITO_BITS  = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    trap_resolve_if.master trap_if
);

    // Exception delegation CSR slice, limited by the datapath width
    localparam int c_EDELEG_W = (XLEN < 16) ? XLEN : 16;

    logic [c_NUM_INT-1:0]  r_pend_int;
    wfi_state_t            r_state, w_state_next;
    logic [WFITO_BITS-1:0] r_wfi_cnt, w_wfi_cnt_next;

    logic                  w_priv_m, w_priv_s, w_priv_u;
    logic [c_NUM_INT-1:0]  w_deleg_s, w_deleg_vs, w_deleg_hs, w_int_mask;
    logic                  w_en_m, w_en_hs, w_en_vs;
    logic [15:0]           w_medeleg, w_hedeleg;
    logic [3:0]            w_int_idx, w_cause, w_exc_code;
    logic                  w_int_valid, w_wfi_timeout, w_trap;
    logic                  w_tgt_hs, w_tgt_vs, w_exc_hs, w_wfi_stall;

    // Registered pending interrupts; deliberately not held by StallW
    always_ff @(posedge clk) begin
        if (reset) r_pend_int <= '0;
        else       r_pend_int <= trap_if.MIP_MIE;
    end

    assign w_priv_m  = (trap_if.PrivilegeModeW == c_PRIV_M);
    assign w_priv_s  = (trap_if.PrivilegeModeW == c_PRIV_S);
    assign w_priv_u  = (trap_if.PrivilegeModeW == c_PRIV_U);
    assign w_medeleg = 16'(trap_if.MEDELEG[c_EDELEG_W-1:0]);
    assign w_hedeleg = 16'(trap_if.HEDELEG[c_EDELEG_W-1:0]);

    // Per-bit interrupt target: VS needs both delegations and a VS-level bit
    assign w_deleg_s  = (S_SUPPORTED != 0) ? trap_if.MIDELEG : '0;
    assign w_deleg_vs = (H_SUPPORTED != 0) ?
                        (w_deleg_s & trap_if.HIDELEG & c_VS_INT_MASK) : '0;
    assign w_deleg_hs = w_deleg_s & ~w_deleg_vs;

    // Delegated interrupts are never taken while running in M
    assign w_en_m  = ~w_priv_m | trap_if.STATUS_MIE;
    assign w_en_hs = ~w_priv_m & (trap_if.VirtModeW | w_priv_u |
                                  (w_priv_s & trap_if.STATUS_SIE));
    assign w_en_vs = ~w_priv_m & trap_if.VirtModeW &
                     (w_priv_u | trap_if.VSSTATUS_SIE);

    assign w_int_mask = r_pend_int & (({c_NUM_INT{w_en_m}}  & ~w_deleg_s)  |
                                      ({c_NUM_INT{w_en_hs}} & w_deleg_hs)  |
                                      ({c_NUM_INT{w_en_vs}} & w_deleg_vs));

    int_priority u_int_priority (
        .i_mask  (w_int_mask),
        .o_idx   (w_int_idx),
        .o_valid (w_int_valid)
    );

    assign w_wfi_timeout = (r_state == c_ST_WAIT) & (&r_wfi_cnt);
    assign w_trap = ~reset & trap_if.InstrValidM &
                    (w_int_valid | trap_if.ExceptionM | w_wfi_timeout);

    // Cause and target: interrupt beats exception, exception beats timeout
    always_comb begin
        w_cause    = '0;
        w_tgt_hs   = 1'b0;
        w_tgt_vs   = 1'b0;
        w_exc_hs   = 1'b0;
        w_exc_code = trap_if.ExceptionM ? trap_if.ExcCodeM : c_EXC_ILLEGAL_INSTR;
        if (w_int_valid) begin
            w_cause  = w_int_idx;
            w_tgt_vs = w_deleg_vs[w_int_idx];
            w_tgt_hs = w_deleg_hs[w_int_idx];
        end else begin
            w_cause  = w_exc_code;
            w_exc_hs = (S_SUPPORTED != 0) & w_medeleg[w_exc_code] & ~w_priv_m;
            w_tgt_vs = w_exc_hs & (H_SUPPORTED != 0) & trap_if.VirtModeW &
                       w_hedeleg[w_exc_code];
            w_tgt_hs = w_exc_hs & ~w_tgt_vs;
        end
    end

    assign trap_if.TrapM      = w_trap;
    assign trap_if.InterruptM = w_trap & w_int_valid;
    assign trap_if.CauseM     = w_trap ? w_cause : 4'd0;
    assign trap_if.TrapToVS   = w_trap & w_tgt_vs;
    assign trap_if.TrapToHS   = w_trap & w_tgt_hs;
    assign trap_if.TrapToM    = w_trap & ~w_tgt_vs & ~w_tgt_hs;
    assign trap_if.DelegateM  = w_trap & (w_tgt_vs | w_tgt_hs);
    assign trap_if.WFIStallM  = ~reset & w_wfi_stall;

    // WFI state and timeout counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_RUN;
            r_wfi_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wfi_cnt <= w_wfi_cnt_next;
        end
    end

    // WFI next state: stall starts in the cycle the WFI is accepted and
    // drops in the cycle the wait ends (wake or timeout)
    always_comb begin
        w_state_next   = r_state;
        w_wfi_cnt_next = r_wfi_cnt;
        w_wfi_stall    = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (trap_if.InstrValidM & trap_if.wfiM & ~w_trap & ~(|r_pend_int)) begin
                    w_state_next   = c_ST_WAIT;
                    w_wfi_cnt_next = '0;
                    w_wfi_stall    = 1'b1;
                end
            end
            c_ST_WAIT: begin
                if ((|r_pend_int) | w_wfi_timeout) begin
                    w_state_next = c_ST_RUN;
                end else begin
                    w_wfi_stall = 1'b1;
                    if (~w_priv_m & trap_if.STATUS_TW & ~(&r_wfi_cnt))
                        w_wfi_cnt_next = r_wfi_cnt + WFITO_BITS'(1);
                end
            end
            default: w_state_next = c_ST_RUN;
        endcase
    end

endmodule
`default_nettype wire
